// File: rtl/mul8_pkg.sv
// Shared widths, operand bundle and helpers for the
// round-robin scheduled 8x8 multiplier.
package mul8_pkg;

  localparam int OPW = 8;
  localparam int PRW = 16;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } opnd_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul8_v9.sv
// Combinational 8x8 unsigned multiplier, exact
// 16-bit product.
module mul8_v9
  import mul8_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PRW-1:0] y
);

  assign y = PRW'(a) * PRW'(b);

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first request
// at or above ptr wins, with wrap-around.
module rr_arb
  import mul8_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < N; j++) begin
      int k;
      k = (int'(ptr) + j) % N;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/mul8_rr_sched.sv
// Shares one mul8_v9 among N requesters through a
// round-robin grant and a 2-stage backpressured pipe.
module mul8_rr_sched
  import mul8_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [OPW*N-1:0] req_a,
  input  logic [OPW*N-1:0] req_b,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  output logic [PRW-1:0]   rsp_y,
  output logic [IDW-1:0]   rsp_id,
  input  logic             rsp_ready
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   gnt;
  opnd_t          win;

  logic           s1_valid;
  opnd_t          s1_op;
  logic [IDW-1:0] s1_id;

  logic           s2_valid;
  logic [PRW-1:0] s2_y;
  logic [IDW-1:0] s2_id;

  logic           s2_adv;
  logic           s1_free;
  logic           xfer;
  logic [PRW-1:0] prod;

  rr_arb #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  mul8_v9 u_mul (
    .a (s1_op.a),
    .b (s1_op.b),
    .y (prod)
  );

  assign s2_adv  = !s2_valid || rsp_ready;
  assign s1_free = !s1_valid || s2_adv;

  // Grants are masked while reset is held so nothing
  // is handed out that the pipe would then drop.
  assign req_ready = (s1_free && !rst) ? gnt : '0;
  assign xfer      = |req_ready;

  assign ptr_nxt = (gnt_idx == IDW'(N - 1)) ?
                   '0 : gnt_idx + 1'b1;

  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        win.a = req_a[OPW*i +: OPW];
        win.b = req_b[OPW*i +: OPW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_id    <= '0;
    end else begin
      if (xfer) ptr <= ptr_nxt;
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_y     <= prod;
        s2_id    <= s1_id;
      end
      if (s1_free) begin
        s1_valid <= xfer;
        s1_op    <= win;
        s1_id    <= gnt_idx;
      end
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_y     = s2_y;
  assign rsp_id    = s2_id;

endmodule

// File: tb/tb_mul8_rr_sched.sv
// Directed and soak bench for mul8_rr_sched with an
// acceptance-order scoreboard.
module tb_mul8_rr_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [15:0]    rsp_y;
  logic [1:0]     rsp_id;
  logic           rsp_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0]  a_v[N];
  logic [7:0]  b_v[N];
  logic [N-1:0] vld;
  logic [7:0]  qa[N][$];
  logic [7:0]  qb[N][$];
  logic [15:0] ey_q[$];
  logic [1:0]  eid_q[$];
  int          mptr;
  int          wcnt[N];
  logic [N-1:0] gnt_s;
  bit          soak;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = vld;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = a_v[i];
      req_b[8*i +: 8] = b_v[i];
    end
  end

  mul8_rr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push(input int id,
                      input logic [7:0] a,
                      input logic [7:0] b);
    qa[id].push_back(a);
    qb[id].push_back(b);
  endtask

  // Requesters: hold until accepted, then next item.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!vld[i] || gnt_s[i]) begin
        if (soak) begin
          vld[i] = 1'($urandom_range(0, 1));
          a_v[i] = 8'($urandom);
          b_v[i] = 8'($urandom);
        end else if (qa[i].size() > 0) begin
          vld[i] = 1'b1;
          a_v[i] = qa[i].pop_front();
          b_v[i] = qb[i].pop_front();
        end else begin
          vld[i] = 1'b0;
        end
      end
    end
    if (soak) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard and round-robin reference.
  always @(negedge clk) begin
    int w;
    int k;
    if (rst) begin
      ey_q.delete();
      eid_q.delete();
      mptr  = 0;
      gnt_s = '0;
      for (int i = 0; i < N; i++) wcnt[i] = 0;
    end else begin
      gnt_s = req_ready;
      if (rsp_valid && rsp_ready) begin
        if (ey_q.size() == 0) begin
          chk("extra_rsp", 1, 0);
        end else begin
          chk("rsp_id", 32'(rsp_id), 32'(eid_q.pop_front()));
          chk("rsp_y", 32'(rsp_y), 32'(ey_q.pop_front()));
        end
      end
      if (req_ready != '0) begin
        w = -1;
        for (int j = 0; j < N; j++) begin
          k = (mptr + j) % N;
          if (w < 0 && req_valid[k]) w = k;
        end
        if (w < 0) begin
          chk("gnt_novalid", 32'(req_ready), 0);
        end else begin
          chk("gnt", 32'(req_ready), 32'(1 << w));
          chk("wait", 32'(wcnt[w] < N), 1);
          for (int i = 0; i < N; i++) begin
            if (i == w) wcnt[i] = 0;
            else if (req_valid[i]) wcnt[i]++;
          end
          eid_q.push_back(2'(w));
          ey_q.push_back({8'd0, a_v[w]} * {8'd0, b_v[w]});
          mptr = (w + 1) % N;
        end
      end
    end
  end

  task automatic drain();
    bit done;
    int qn;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      qn = 0;
      for (int i = 0; i < N; i++) qn += qa[i].size();
      done = (vld == '0) && (qn == 0) &&
             (ey_q.size() == 0) && !rsp_valid;
    end
    chk("drain", 32'(done), 1);
  endtask

  task automatic single(input int id,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] y);
    bit hit;
    hit = 1'b0;
    push(id, a, b);
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      hit = req_ready[id];
    end
    chk("acc", 32'(hit), 1);
    @(negedge clk);
    chk("lat1", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("lat2", 32'(rsp_valid), 1);
    chk("y", 32'(rsp_y), 32'(y));
    chk("id", 32'(rsp_id), 32'(id));
  endtask

  initial begin
    int cnt;
    int acc;
    vld       = '0;
    soak      = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
      push(i, 8'(i + 1), 8'(2 * i + 3));
    end

    repeat (3) @(negedge clk);
    chk("rst_rv", 32'(rsp_valid), 0);
    chk("rst_rr", 32'(req_ready), 0);
    chk("rst_y", 32'(rsp_y), 0);
    chk("rst_id", 32'(rsp_id), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("first_gnt", 32'(req_ready), 32'h1);
    drain();

    single(0, 8'd13, 8'd11, 16'd143);
    single(2, 8'd255, 8'd255, 16'hFE01);
    single(1, 8'd0, 8'd200, 16'h0000);
    single(3, 8'd1, 8'd255, 16'h00FF);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++)
        push(i, 8'(16 * i + k + 1), 8'(200 - 7 * k - i));
    repeat (5) @(negedge clk);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("tput", 32'(cnt), 8);
    drain();

    @(posedge clk);
    #2;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++)
        push(i, 8'(i + 10), 8'(k + 3));
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) acc++;
      if (c == 3) begin
        chk("bp_y0", 32'(rsp_y), 30);
        chk("bp_id0", 32'(rsp_id), 0);
      end
    end
    chk("bp_acc", 32'(acc), 2);
    chk("bp_rdy", 32'(req_ready), 0);
    chk("bp_rv", 32'(rsp_valid), 1);
    chk("bp_y", 32'(rsp_y), 30);
    chk("bp_id", 32'(rsp_id), 0);
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rise", 32'(req_ready), 32'h4);
    drain();

    @(posedge clk);
    #2;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++)
        push(i, 8'(40 + i), 8'(5 + k));
    repeat (4) @(negedge clk);
    chk("mid_rv", 32'(rsp_valid), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rv", 32'(rsp_valid), 0);
    chk("mid_rst_rr", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_first", 32'(req_ready), 32'h1);
    drain();

    @(posedge clk);
    #2;
    soak = 1'b1;
    repeat (10000) @(posedge clk);
    #2;
    soak = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul8_rr_sched.md
# mul8_rr_sched

Round-robin scheduler that shares one combinational 8×8 unsigned multiplier (mul8_v9) among N requesters. Each requester presents an operand pair over a valid/ready handshake. The block arbitrates, registers operands, multiplies, and returns a tagged 16-bit product through a 2-stage backpressured pipeline. It sits between multiple client blocks and the single multiplier instance.

## Interface
- N, default 4: number of requesters, 2..8.
- IDW, default 2: width of the requester ID, equal to clog2(N).
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-requester operand valid.
- req_a  in  8*N  operand A; requester i occupies bits [8i+7:8i].
- req_b  in  8*N  operand B; same packing as req_a.
- req_ready  out  N  per-requester accept; at most one bit high per cycle.
- rsp_valid  out  1  product valid.
- rsp_y  out  16  unsigned product a*b.
- rsp_id  out  IDW  index of the requester that issued the product.
- rsp_ready  in  1  downstream accept.

## Operation
- Transfer rules:
  - A request transfer occurs when req_valid[i] && req_ready[i].
  - A response transfer occurs when rsp_valid && rsp_ready.
- Requester obligations: once req_valid[i] is asserted, hold req_valid[i] and the operands stable until the transfer. A requester must not retract a pending request.
- Arbitration (combinational):
  - Search starts at pointer ptr and proceeds upward with wrap-around.
  - The first i with req_valid[i] set wins.
  - req_ready[winner] = s1_free. All other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid.
- Pointer update: on a request transfer from requester k, ptr ← (k+1) mod N. With no transfer, ptr holds.
- Stage S1 registers: s1_valid, s1_a, s1_b, s1_id.
- Stage S2 registers: s2_valid, s2_y = s1_a*s1_b, s2_id. S2 drives the outputs: rsp_valid = s2_valid, rsp_y = s2_y, rsp_id = s2_id.
- Advance conditions:
  - s2_adv = !s2_valid || rsp_ready
  - s1_free = !s1_valid || s2_adv
- On s2_adv:
  - s2_valid ← s1_valid.
  - s2_y and s2_id load from S1.
- On s1_free:
  - s1_valid ← request transfer.
  - s1_a, s1_b and s1_id load from the winner.
- Width rules:
  - Unsigned arithmetic only; the product is exact in 16 bits.
  - Maximum case: 255*255 = 16'hFE01.
- Ordering: responses leave in acceptance order. No reordering and no drops.

## Timing
- Reset (async assert, sync deassert handled by the system): ptr=0, s1_valid=0, s2_valid=0, s1/s2 data=0.
  - Outputs during reset: rsp_valid=0, rsp_y=0, rsp_id=0.
  - req_ready=0 while rst is high.
- Latency: a request accepted at edge t gives rsp_valid high after edge t+1 (second edge), provided there is no stall.
- Throughput: 1 product/cycle with rsp_ready held high.
- Stall: with rsp_ready=0 and S2 full, S2 holds.
  - S1 accepts one more request if empty, then req_ready goes to all 0.
  - Maximum of 2 products in flight.
- Stall with S2 full and S1 full, rsp_ready rising: on the next edge, S2 takes S1 and S1 takes a new winner in the same edge.
- Single active requester: it is granted every cycle regardless of ptr.
- Simultaneous requests: ptr rotates, so with all N requesting, grants go ptr, ptr+1, … with wrap from N-1 to 0.
- Reset mid-operation: in-flight products are discarded and no rsp_valid is produced for them. Requesters re-present their requests after reset.
- rsp_y, rsp_id and rsp_valid are stable while rsp_valid && !rsp_ready.

## Structure
- Shared package mul8_pkg:
  - OPW=8 and PRW=16 constants.
  - The clog2 helper function.
- Sub-module rr_arb:
  - Parameter N; inputs req and ptr; outputs a one-hot grant and the grant index.
  - Purely combinational.
  - The pointer register stays in mul8_rr_sched.
- The multiplier is one mul8_v9 instance fed by s1_a/s1_b. Its output is registered into s2_y.

## Test plan
- Reset check: assert rst mid-stream with 2 products in flight → rsp_valid=0, req_ready=0 during reset. After release, ptr=0 and requester 0 wins first.
- Single request: req0 a=8'd13, b=8'd11 → rsp_valid exactly 2 edges after acceptance, rsp_y=16'd143, rsp_id=0.
- Boundary operands:
  - 255*255 → 16'hFE01.
  - 0*200 → 16'h0000.
  - 1*255 → 16'h00FF.
- Fairness (N=4): all four requesters valid continuously with rsp_ready=1 → grant order 0,1,2,3,0,1… Each response is checked against a*b, and one product appears per cycle.
- Backpressure: rsp_ready=0 for 5 cycles while all request → exactly 2 acceptances, then req_ready=0. rsp_y and rsp_id hold stable. After release, no loss or duplication, and products come out in acceptance order.
- Random soak: 10k cycles with random req_valid and rsp_ready → scoreboard matches every {id, a*b} in acceptance order. No requester waits more than N grants.
